hazard_ctrl_unit: RTL

- Feedback-side controller for the 5-stage pipeline; runs opposite to the forward-flowing ID/EX register.
- Inputs: the decoded instruction in ID and the taken-branch result from EX.
- Keeps its own shadow copy of destination/control fields for the EX, MEM and WB stages.
- Outputs: stall/flush controls to the IF/ID and ID/EX pipeline registers, and forwarding selects to the EX operand muxes.

---
 rtl/hazard_ctrl_unit_if.sv | 41 ++++
 rtl/hazard_ctrl_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline <-> hazard controller handshake bundle
//
// Purpose: groups the decoded-ID fields, the EX branch result and the
// stall/flush/forward controls exchanged between the datapath and
// hazard_ctrl_unit.
// Ports (signals):
//   Rs1D, Rs2D, A3D [4:0]  ID source/destination registers
//   UsesRs1D, UsesRs2D     ID instruction reads Rs1/Rs2
//   RegWriteD              ID instruction writes A3D
//   MEM_CtrlD [1:0]        bit0 = load, bit1 = store
//   BranchTakenE           branch/jump resolved taken in EX
//   StallF, StallD         hold PC / IF-ID
//   FlushD, FlushE         bubble IF-ID / ID-EX
//   ForwardAE, ForwardBE   EX operand selects (00 RD, 10 MEM, 01 WB)
// Modports: master = datapath side, slave = hazard controller.
interface hazard_ctrl_unit_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic       UsesRs1D;
  logic       UsesRs2D;
  logic [4:0] A3D;
  logic       RegWriteD;
  logic [1:0] MEM_CtrlD;
  logic       BranchTakenE;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;

  modport master (
    output Rs1D, Rs2D, UsesRs1D, UsesRs2D, A3D, RegWriteD, MEM_CtrlD, BranchTakenE,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, A3D, RegWriteD, MEM_CtrlD, BranchTakenE,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - load-use stall, branch flush and EX forwarding control
//
// Purpose: keeps a shadow copy of the EX/MEM/WB destination and control
// fields, detects load-use hazards against the instruction in ID, issues
// stall/flush controls and selects EX operand forwarding paths. Counts
// stall and flush cycles in saturating counters.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   hz         hazard_ctrl_unit_if.slave (ID fields in, controls out)
//   stall_cnt  saturating count of load-use stall cycles
//   flush_cnt  saturating count of taken-branch flush cycles
module hazard_ctrl_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_unit_if.slave hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Shadow pipeline state
  logic [4:0] e_rs1_q, e_rs1_d;
  logic [4:0] e_rs2_q, e_rs2_d;
  logic [4:0] e_a3_q,  e_a3_d;
  logic       e_rw_q,  e_rw_d;
  logic       e_ld_q,  e_ld_d;
  logic [4:0] m_a3_q,  m_a3_d;
  logic       m_rw_q,  m_rw_d;
  logic       m_ld_q,  m_ld_d;
  logic [4:0] w_a3_q,  w_a3_d;
  logic       w_rw_q,  w_rw_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;

  // The M-slot load flag and the store bit are tracked but never consumed:
  // a load in M can only match after a missed stall, and stores never stall.
  logic unused_sig;
  assign unused_sig = &{1'b0, m_ld_q, hz.MEM_CtrlD[1]};

  always_comb begin
    lu = e_ld_q && (e_a3_q != 5'd0) &&
         ((hz.UsesRs1D && (e_a3_q == hz.Rs1D)) ||
          (hz.UsesRs2D && (e_a3_q == hz.Rs2D)));

    // A taken branch squashes the ID instruction, so it overrides the stall.
    hz.FlushD = hz.BranchTakenE;
    hz.StallF = lu && !hz.BranchTakenE;
    hz.StallD = lu && !hz.BranchTakenE;
    hz.FlushE = lu || hz.BranchTakenE;

    // MEM beats WB so the youngest producer wins; x0 never forwards.
    hz.ForwardAE = 2'b00;
    if (m_rw_q && (m_a3_q != 5'd0) && (m_a3_q == e_rs1_q))      hz.ForwardAE = 2'b10;
    else if (w_rw_q && (w_a3_q != 5'd0) && (w_a3_q == e_rs1_q)) hz.ForwardAE = 2'b01;

    hz.ForwardBE = 2'b00;
    if (m_rw_q && (m_a3_q != 5'd0) && (m_a3_q == e_rs2_q))      hz.ForwardBE = 2'b10;
    else if (w_rw_q && (w_a3_q != 5'd0) && (w_a3_q == e_rs2_q)) hz.ForwardBE = 2'b01;
  end

  always_comb begin
    w_a3_d = m_a3_q;
    w_rw_d = m_rw_q;
    m_a3_d = e_a3_q;
    m_rw_d = e_rw_q;
    m_ld_d = e_ld_q;
    e_rs1_d = hz.Rs1D;
    e_rs2_d = hz.Rs2D;
    e_a3_d  = hz.A3D;
    e_rw_d  = hz.RegWriteD;
    e_ld_d  = hz.MEM_CtrlD[0];
    if (hz.FlushE) begin
      e_rs1_d = 5'd0;
      e_rs2_d = 5'd0;
      e_a3_d  = 5'd0;
      e_rw_d  = 1'b0;
      e_ld_d  = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (hz.StallD && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (hz.BranchTakenE && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_rs1_q <= 5'd0;
      e_rs2_q <= 5'd0;
      e_a3_q  <= 5'd0;
      e_rw_q  <= 1'b0;
      e_ld_q  <= 1'b0;
      m_a3_q  <= 5'd0;
      m_rw_q  <= 1'b0;
      m_ld_q  <= 1'b0;
      w_a3_q  <= 5'd0;
      w_rw_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      e_rs1_q <= e_rs1_d;
      e_rs2_q <= e_rs2_d;
      e_a3_q  <= e_a3_d;
      e_rw_q  <= e_rw_d;
      e_ld_q  <= e_ld_d;
      m_a3_q  <= m_a3_d;
      m_rw_q  <= m_rw_d;
      m_ld_q  <= m_ld_d;
      w_a3_q  <= w_a3_d;
      w_rw_q  <= w_rw_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
